// File: rtl/risk_limit_mem.sv
// Per-client risk-limit store: each entry is {max, accumulated}, with read, set-max, saturating
// accumulate and check-and-accumulate behind valid/ready handshakes and a fixed response latency.
// States: INIT clear sweep | IDLE accept request | EXEC single-cycle RMW | WAIT latency pad | RESP hold response
module risk_limit_mem #(
    parameter int CLIENTS = 512,
    parameter int ADDR_W  = $clog2(CLIENTS),
    parameter int AMT_W   = 16,
    parameter int LAT     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_client,
    input  logic [AMT_W-1:0]  i_req_amt,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [AMT_W-1:0]  o_rsp_max,
    output logic [AMT_W-1:0]  o_rsp_acc,
    output logic              o_rsp_reject,
    output logic              o_rsp_sat,
    output logic              o_rsp_err,
    output logic              o_init_done
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_SET_MAX = 2'b01;
    localparam logic [1:0] OP_ACCUM   = 2'b10;
    localparam logic [1:0] OP_CHECK   = 2'b11;

    // EXEC consumes one of the LAT cycles; WAIT covers the remaining LAT-1.
    localparam logic [3:0] WAIT_LOAD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
    localparam logic [ADDR_W:0]   CLIENT_LIM = (ADDR_W + 1)'(CLIENTS);
    localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(CLIENTS - 1);

    state_t r_state;
    state_t w_next;

    logic [2*AMT_W-1:0] r_mem [CLIENTS];

    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_client;
    logic [AMT_W-1:0]  r_amt;
    logic [ADDR_W-1:0] r_cnt;
    logic [3:0]        r_wait;
    logic              r_init_done;
    logic [AMT_W-1:0]  r_rsp_max;
    logic [AMT_W-1:0]  r_rsp_acc;
    logic              r_rsp_reject;
    logic              r_rsp_sat;
    logic              r_rsp_err;

    logic               w_cnt_last;
    logic               w_in_range;
    logic [2*AMT_W-1:0] w_entry;
    logic [AMT_W-1:0]   w_cur_max;
    logic [AMT_W-1:0]   w_cur_acc;
    logic [AMT_W:0]     w_sum;
    logic [AMT_W-1:0]   w_new_max;
    logic [AMT_W-1:0]   w_new_acc;
    logic               w_reject;
    logic               w_sat;
    logic               w_exec_wr;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [2*AMT_W-1:0] w_wdata;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: if (w_cnt_last) w_next = S_IDLE;
            S_IDLE: if (i_req_valid) w_next = S_EXEC;
            S_EXEC: w_next = (LAT == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_wait == 4'd0) w_next = S_RESP;
            S_RESP: if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_INIT;
        endcase
    end

    // Out-of-range IDs never touch the array, so they cannot alias onto a valid entry.
    assign w_in_range = ({1'b0, r_client} < CLIENT_LIM);
    assign w_entry    = w_in_range ? r_mem[r_client] : '0;
    assign w_cur_max  = w_entry[2*AMT_W-1:AMT_W];
    assign w_cur_acc  = w_entry[AMT_W-1:0];
    assign w_sum      = {1'b0, w_cur_acc} + {1'b0, r_amt};

    always_comb begin
        w_new_max = w_cur_max;
        w_new_acc = w_cur_acc;
        w_reject  = 1'b0;
        w_sat     = 1'b0;
        w_exec_wr = 1'b0;
        case (r_op)
            OP_READ: ;
            OP_SET_MAX: begin
                w_new_max = r_amt;
                w_exec_wr = 1'b1;
            end
            OP_ACCUM: begin
                w_sat     = w_sum[AMT_W];
                w_new_acc = w_sum[AMT_W] ? {AMT_W{1'b1}} : w_sum[AMT_W-1:0];
                w_exec_wr = 1'b1;
            end
            OP_CHECK: begin
                // A zero amount is always admissible, even if acc already exceeds max.
                w_reject = (r_amt != '0) && (w_sum > {1'b0, w_cur_max});
                if (!w_reject) begin
                    w_new_acc = w_sum[AMT_W-1:0];
                    w_exec_wr = 1'b1;
                end
            end
            default: ;
        endcase
        if (!w_in_range) begin
            w_new_max = '0;
            w_new_acc = '0;
            w_reject  = 1'b0;
            w_sat     = 1'b0;
            w_exec_wr = 1'b0;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_client;
        w_wdata = {w_new_max, w_new_acc};
        if (r_state == S_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = '0;
        end else if (r_state == S_EXEC) begin
            w_we = w_exec_wr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op         <= '0;
            r_client     <= '0;
            r_amt        <= '0;
            r_cnt        <= '0;
            r_wait       <= '0;
            r_init_done  <= 1'b0;
            r_rsp_max    <= '0;
            r_rsp_acc    <= '0;
            r_rsp_reject <= 1'b0;
            r_rsp_sat    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_cnt_last) begin
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op     <= i_req_op;
                        r_client <= i_req_client;
                        r_amt    <= i_req_amt;
                    end
                end
                S_EXEC: begin
                    r_wait       <= WAIT_LOAD;
                    r_rsp_max    <= w_new_max;
                    r_rsp_acc    <= w_new_acc;
                    r_rsp_reject <= w_reject;
                    r_rsp_sat    <= w_sat;
                    r_rsp_err    <= !w_in_range;
                end
                S_WAIT: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_max    = r_rsp_max;
    assign o_rsp_acc    = r_rsp_acc;
    assign o_rsp_reject = r_rsp_reject;
    assign o_rsp_sat    = r_rsp_sat;
    assign o_rsp_err    = r_rsp_err;
    assign o_init_done  = r_init_done;

endmodule

// File: tb/tb_risk_limit_mem.sv
// Directed bench for risk_limit_mem: three builds (default, LAT=1, CLIENTS=300) share clock,
// reset and request fields; each has its own handshake signals.
module tb_risk_limit_mem;

    localparam int AW = 9;
    localparam int N_DUT = 3;
    localparam logic [1:0] OP_READ = 2'b00, OP_SET = 2'b01, OP_ACC = 2'b10, OP_CHK = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]  req_op = '0;
    logic [AW-1:0] req_client = '0;
    logic [15:0] req_amt = '0;

    logic [N_DUT-1:0] req_valid = '0;
    logic [N_DUT-1:0] rsp_ready = '0;
    logic [N_DUT-1:0] req_ready, rsp_valid, rsp_reject, rsp_sat, rsp_err, init_done;
    logic [15:0] rsp_max [N_DUT];
    logic [15:0] rsp_acc [N_DUT];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    risk_limit_mem #(.CLIENTS(512), .AMT_W(16), .LAT(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_op(req_op), .i_req_client(req_client), .i_req_amt(req_amt),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_max(rsp_max[0]),
        .o_rsp_acc(rsp_acc[0]), .o_rsp_reject(rsp_reject[0]), .o_rsp_sat(rsp_sat[0]),
        .o_rsp_err(rsp_err[0]), .o_init_done(init_done[0]));

    risk_limit_mem #(.CLIENTS(512), .AMT_W(16), .LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_op(req_op), .i_req_client(req_client), .i_req_amt(req_amt),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_max(rsp_max[1]),
        .o_rsp_acc(rsp_acc[1]), .o_rsp_reject(rsp_reject[1]), .o_rsp_sat(rsp_sat[1]),
        .o_rsp_err(rsp_err[1]), .o_init_done(init_done[1]));

    risk_limit_mem #(.CLIENTS(300), .AMT_W(16), .LAT(4)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_req_op(req_op), .i_req_client(req_client), .i_req_amt(req_amt),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_max(rsp_max[2]),
        .o_rsp_acc(rsp_acc[2]), .o_rsp_reject(rsp_reject[2]), .o_rsp_sat(rsp_sat[2]),
        .o_rsp_err(rsp_err[2]), .o_init_done(init_done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Release reset and count cycles until each build raises req_ready.
    task automatic sweep(input string tag);
        int n [N_DUT];
        logic [N_DUT-1:0] seen;
        seen = '0;
        for (int d = 0; d < N_DUT; d++) n[d] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 2000 && seen != '1; t++) begin
            @(posedge clk); #1;
            for (int d = 0; d < N_DUT; d++) begin
                if (!seen[d]) begin
                    n[d]++;
                    if (req_ready[d]) seen[d] = 1'b1;
                end
            end
        end
        chk({tag, "/sweep0"}, n[0], 512);
        chk({tag, "/sweep1"}, n[1], 512);
        chk({tag, "/sweep2"}, n[2], 300);
        chk({tag, "/init_done"}, {29'd0, init_done}, 3'b111);
    endtask

    task automatic do_req(input string tag, input int d, input logic [1:0] op,
                          input logic [AW-1:0] c, input logic [15:0] amt,
                          input int exp_lat, input int hold,
                          input logic [15:0] emax, input logic [15:0] eacc,
                          input logic erej, input logic esat, input logic eerr);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/req_ready"}, req_ready[d], 1'b1);
        req_op = op;
        req_client = c;
        req_amt = amt;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        // Garbage on the request bus after accept must not leak into the operation.
        req_client = c ^ 9'h001;
        req_amt = ~amt;
        req_op = ~op;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/latency"}, n, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "/rsp_valid"}, rsp_valid[d], 1'b1);
            chk({tag, "/max"}, rsp_max[d], emax);
            chk({tag, "/acc"}, rsp_acc[d], eacc);
            chk({tag, "/flags"}, {rsp_reject[d], rsp_sat[d], rsp_err[d]}, {erej, esat, eerr});
            if (h < hold) begin
                chk({tag, "/busy"}, req_ready[d], 1'b0);
                @(posedge clk); #1;
            end
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk({tag, "/rsp_drop"}, rsp_valid[d], 1'b0);
        chk({tag, "/idle"}, req_ready[d], 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst/outs", {req_ready, rsp_valid, init_done}, 9'd0);
        chk("rst/data", {rsp_max[0], rsp_acc[0]}, 32'd0);
        sweep("t1");

        do_req("t1/rd0", 0, OP_READ, 9'h1AB, 16'h5555, 4, 0, 16'h0, 16'h0, 0, 0, 0);
        do_req("t1/rd511", 0, OP_READ, 9'd511, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 0);

        do_req("t2/set", 0, OP_SET, 9'd5, 16'h0100, 4, 0, 16'h0100, 16'h0000, 0, 0, 0);
        do_req("t2/ca_f0", 0, OP_CHK, 9'd5, 16'h00F0, 4, 3, 16'h0100, 16'h00F0, 0, 0, 0);
        do_req("t2/ca_eq", 0, OP_CHK, 9'd5, 16'h0010, 4, 0, 16'h0100, 16'h0100, 0, 0, 0);
        do_req("t2/ca_over", 0, OP_CHK, 9'd5, 16'h0001, 4, 0, 16'h0100, 16'h0100, 1, 0, 0);
        do_req("t2/rd", 0, OP_READ, 9'd5, 16'h0, 4, 0, 16'h0100, 16'h0100, 0, 0, 0);

        do_req("t3/acc1", 0, OP_ACC, 9'd7, 16'hFFF0, 4, 0, 16'h0, 16'hFFF0, 0, 0, 0);
        do_req("t3/acc_sat", 0, OP_ACC, 9'd7, 16'h0020, 4, 0, 16'h0, 16'hFFFF, 0, 1, 0);
        do_req("t3/ca_max0", 0, OP_CHK, 9'd7, 16'h0001, 4, 0, 16'h0, 16'hFFFF, 1, 0, 0);
        do_req("t3/ca_zero", 0, OP_CHK, 9'd7, 16'h0000, 4, 0, 16'h0, 16'hFFFF, 0, 0, 0);

        do_req("t4/l1_set", 1, OP_SET, 9'd3, 16'h0050, 1, 3, 16'h0050, 16'h0000, 0, 0, 0);
        do_req("t4/l1_ca", 1, OP_CHK, 9'd3, 16'h0050, 1, 0, 16'h0050, 16'h0050, 0, 0, 0);
        do_req("t4/l1_rej", 1, OP_CHK, 9'd3, 16'h0001, 1, 0, 16'h0050, 16'h0050, 1, 0, 0);
        do_req("t4/l1_acc", 1, OP_ACC, 9'd3, 16'h0001, 1, 0, 16'h0050, 16'h0051, 0, 0, 0);

        do_req("t5/set144", 2, OP_SET, 9'd144, 16'h1234, 4, 0, 16'h1234, 16'h0, 0, 0, 0);
        do_req("t5/set400", 2, OP_SET, 9'd400, 16'hBEEF, 4, 0, 16'h0, 16'h0, 0, 0, 1);
        do_req("t5/acc400", 2, OP_ACC, 9'd400, 16'hFFFF, 4, 0, 16'h0, 16'h0, 0, 0, 1);
        do_req("t5/rd400", 2, OP_READ, 9'd400, 16'h0, 4, 2, 16'h0, 16'h0, 0, 0, 1);
        do_req("t5/rd144", 2, OP_READ, 9'd144, 16'h0, 4, 0, 16'h1234, 16'h0, 0, 0, 0);
        do_req("t5/rd299", 2, OP_READ, 9'd299, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 0);
        do_req("t5/rd300", 2, OP_READ, 9'd300, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 1);

        // Reset while an ACCUM sits in WAIT: its write has landed but the sweep must wipe it.
        @(negedge clk);
        req_op = OP_ACC;
        req_client = 9'd9;
        req_amt = 16'h0077;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t6/in_wait", {rsp_valid[0], req_ready[0]}, 2'b00);
        chk("t6/pre_acc", rsp_acc[0], 16'h0077);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6/rst_ctl", {rsp_valid, req_ready, init_done}, 9'd0);
        chk("t6/rst_data", {rsp_max[0], rsp_acc[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6/no_rsp", rsp_valid[0], 1'b0);
        sweep("t6");
        do_req("t6/rd9", 0, OP_READ, 9'd9, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 0);
        do_req("t6/rd5", 0, OP_READ, 9'd5, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 0);
        do_req("t6/rd144", 2, OP_READ, 9'd144, 16'h0, 4, 0, 16'h0, 16'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
